mem_data_lsu_req: RTL and testbench

- Initiator side of the data-memory port; issues single reads/writes to the sync data-memory responder (pMemData_*).
- Takes one load/store request at a time from the execute stage over a valid/ready handshake.
- Drives enable/address/data/byte-mask, waits out the 1-cycle synchronous read latency, then returns sign/zero-extended load data or a store ack.
- Detects misaligned and illegal accesses without touching memory.

---
 rtl/mem_data_lsu_req.sv | 168 ++++++++++++++++
 tb/tb_mem_data_lsu_req.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_lsu_req.sv
// Load/store initiator for the synchronous data-memory port.
// Issues one access at a time and returns extended load data or a store acknowledge.
module mem_data_lsu_req #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  pLsu_pReq_bValid,
   output logic                  pLsu_pReq_bReady,
   input  logic                  pLsu_pReq_bWen,
   input  logic [2:0]            pLsu_pReq_bFunct3,
   input  logic [ADDR_WIDTH-1:0] pLsu_pReq_bAddr,
   input  logic [DATA_WIDTH-1:0] pLsu_pReq_bData,
   output logic                  pLsu_pRsp_bValid,
   input  logic                  pLsu_pRsp_bReady,
   output logic [DATA_WIDTH-1:0] pLsu_pRsp_bData,
   output logic                  pLsu_pRsp_bErr,
   output logic                  pMemData_pRd_bEn,
   output logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr,
   input  logic [DATA_WIDTH-1:0] pMemData_pRd_bData,
   output logic                  pMemData_pWr_bEn,
   output logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr,
   output logic [DATA_WIDTH-1:0] pMemData_pWr_bData,
   output logic                  pMemData_pWr_bMask_0,
   output logic                  pMemData_pWr_bMask_1,
   output logic                  pMemData_pWr_bMask_2,
   output logic                  pMemData_pWr_bMask_3
);

   typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

   state_t                state_q;
   logic [2:0]            funct3_q;
   logic                  reqReady_q;
   logic                  rdEn_q;
   logic [ADDR_WIDTH-1:0] rdAddr_q;
   logic                  wrEn_q;
   logic [ADDR_WIDTH-1:0] wrAddr_q;
   logic [DATA_WIDTH-1:0] wrData_q;
   logic [3:0]            wrMask_q;
   logic                  rspValid_q;
   logic [DATA_WIDTH-1:0] rspData_q;
   logic                  rspErr_q;

   logic       reqIllegal;
   logic       reqMisaligned;
   logic [3:0] reqMask;

   function automatic logic [DATA_WIDTH-1:0] formatLoad(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] w);
      case (f3)
         3'b000:  formatLoad = {{(DATA_WIDTH-8){w[7]}}, w[7:0]};
         3'b001:  formatLoad = {{(DATA_WIDTH-16){w[15]}}, w[15:0]};
         3'b100:  formatLoad = {{(DATA_WIDTH-8){1'b0}}, w[7:0]};
         3'b101:  formatLoad = {{(DATA_WIDTH-16){1'b0}}, w[15:0]};
         default: formatLoad = w;
      endcase
   endfunction

   // Errors are decided straight from the request so a bad access never reaches memory
   always_comb begin
      reqIllegal    = 1'b0;
      reqMisaligned = 1'b0;
      reqMask       = 4'b1111;
      if (pLsu_pReq_bWen) begin
         reqIllegal = pLsu_pReq_bFunct3[2] || (pLsu_pReq_bFunct3[1:0] == 2'b11);
      end else begin
         reqIllegal = (pLsu_pReq_bFunct3 == 3'b011) || (pLsu_pReq_bFunct3[2:1] == 2'b11);
      end
      reqMisaligned = ((pLsu_pReq_bFunct3[1:0] == 2'b01) && pLsu_pReq_bAddr[0]) ||
                      ((pLsu_pReq_bFunct3[1:0] == 2'b10) && (pLsu_pReq_bAddr[1:0] != 2'b00));
      case (pLsu_pReq_bFunct3[1:0])
         2'b00:   reqMask = 4'b0001;
         2'b01:   reqMask = 4'b0011;
         default: reqMask = 4'b1111;
      endcase
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q    <= IDLE;
         funct3_q   <= 3'b000;
         reqReady_q <= 1'b1;
         rdEn_q     <= 1'b0;
         rdAddr_q   <= '0;
         wrEn_q     <= 1'b0;
         wrAddr_q   <= '0;
         wrData_q   <= '0;
         wrMask_q   <= 4'b0000;
         rspValid_q <= 1'b0;
         rspData_q  <= '0;
         rspErr_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pLsu_pReq_bValid && reqReady_q) begin
                  funct3_q   <= pLsu_pReq_bFunct3;
                  reqReady_q <= 1'b0;
                  if (reqIllegal || reqMisaligned) begin
                     state_q    <= RESP;
                     rspValid_q <= 1'b1;
                     rspErr_q   <= 1'b1;
                     rspData_q  <= '0;
                  end else if (pLsu_pReq_bWen) begin
                     state_q  <= WR;
                     wrEn_q   <= 1'b1;
                     wrAddr_q <= pLsu_pReq_bAddr;
                     wrData_q <= pLsu_pReq_bData;
                     wrMask_q <= reqMask;
                  end else begin
                     state_q  <= RD;
                     rdEn_q   <= 1'b1;
                     rdAddr_q <= pLsu_pReq_bAddr;
                  end
               end
            end
            RD: begin
               state_q  <= RD_WAIT;
               rdEn_q   <= 1'b0;
               rdAddr_q <= '0;
            end
            // Memory data is already address-relative, so only extension is applied
            RD_WAIT: begin
               state_q    <= RESP;
               rspValid_q <= 1'b1;
               rspErr_q   <= 1'b0;
               rspData_q  <= formatLoad(funct3_q, pMemData_pRd_bData);
            end
            WR: begin
               state_q    <= RESP;
               wrEn_q     <= 1'b0;
               wrAddr_q   <= '0;
               wrData_q   <= '0;
               wrMask_q   <= 4'b0000;
               rspValid_q <= 1'b1;
               rspErr_q   <= 1'b0;
               rspData_q  <= '0;
            end
            RESP: begin
               if (pLsu_pRsp_bReady) begin
                  state_q    <= IDLE;
                  reqReady_q <= 1'b1;
                  rspValid_q <= 1'b0;
                  rspErr_q   <= 1'b0;
                  rspData_q  <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pLsu_pReq_bReady     = reqReady_q;
   assign pLsu_pRsp_bValid     = rspValid_q;
   assign pLsu_pRsp_bData      = rspData_q;
   assign pLsu_pRsp_bErr       = rspErr_q;
   assign pMemData_pRd_bEn     = rdEn_q;
   assign pMemData_pRd_bAddr   = rdAddr_q;
   assign pMemData_pWr_bEn     = wrEn_q;
   assign pMemData_pWr_bAddr   = wrAddr_q;
   assign pMemData_pWr_bData   = wrData_q;
   assign pMemData_pWr_bMask_0 = wrMask_q[3];
   assign pMemData_pWr_bMask_1 = wrMask_q[2];
   assign pMemData_pWr_bMask_2 = wrMask_q[1];
   assign pMemData_pWr_bMask_3 = wrMask_q[0];

endmodule

// File: tb/tb_mem_data_lsu_req.sv
// Scoreboard bench for the load/store initiator: expected responses are queued at
// request time and compared as each response is retired.
module tb_mem_data_lsu_req;

   logic        iClock = 1'b0;
   logic        iReset = 1'b0;
   logic        reqValid = 1'b0, reqWen = 1'b0, rspReady = 1'b0;
   logic [2:0]  reqF3 = 3'b000;
   logic [31:0] reqAddr = '0, reqData = '0;
   logic        reqReady, rspValid, rspErr;
   logic [31:0] rspData;
   logic        rdEn, wrEn;
   logic [31:0] rdAddr, wrAddr, wrData;
   logic        m0, m1, m2, m3;
   logic [31:0] memRet = '0, memRdData = '0;

   int errors = 0;
   int checks = 0;

   typedef struct {logic [31:0] data; logic err; int lat;} exp_t;
   exp_t sbQ[$];

   int rdPulses = 0, wrPulses = 0, bothHigh = 0, idleLeak = 0;
   logic [31:0] lastRdAddr = '0, lastWrAddr = '0, lastWrData = '0;
   logic [3:0]  lastWrMask = '0;

   always #5 iClock = ~iClock;

   mem_data_lsu_req #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .iClock(iClock), .iReset(iReset),
      .pLsu_pReq_bValid(reqValid), .pLsu_pReq_bReady(reqReady),
      .pLsu_pReq_bWen(reqWen), .pLsu_pReq_bFunct3(reqF3),
      .pLsu_pReq_bAddr(reqAddr), .pLsu_pReq_bData(reqData),
      .pLsu_pRsp_bValid(rspValid), .pLsu_pRsp_bReady(rspReady),
      .pLsu_pRsp_bData(rspData), .pLsu_pRsp_bErr(rspErr),
      .pMemData_pRd_bEn(rdEn), .pMemData_pRd_bAddr(rdAddr),
      .pMemData_pRd_bData(memRdData),
      .pMemData_pWr_bEn(wrEn), .pMemData_pWr_bAddr(wrAddr),
      .pMemData_pWr_bData(wrData),
      .pMemData_pWr_bMask_0(m0), .pMemData_pWr_bMask_1(m1),
      .pMemData_pWr_bMask_2(m2), .pMemData_pWr_bMask_3(m3)
   );

   // Synchronous memory responder: data appears the cycle after the enable edge
   always @(posedge iClock) begin
      if (rdEn) memRdData <= memRet;
   end

   // Bus monitor tallies enable pulses and protocol violations
   always @(negedge iClock) begin
      if (rdEn) begin rdPulses++; lastRdAddr = rdAddr; end
      if (wrEn) begin
         wrPulses++; lastWrAddr = wrAddr; lastWrData = wrData;
         lastWrMask = {m0, m1, m2, m3};
      end
      if (rdEn && wrEn) bothHigh++;
      if ((!rdEn && rdAddr != 0) || (!wrEn && (wrAddr != 0 || wrData != 0 || {m0,m1,m2,m3} != 0)))
         idleLeak++;
   end

   function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [31:0] w);
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b010:  return w;
         3'b100:  return {24'h0, w[7:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   // Drives one request through the handshake, queueing its expected response
   task automatic sendReq(input logic w, input logic [2:0] f3, input logic [31:0] a, d,
                          input bit push, input logic [31:0] ed, input logic ee, input int el);
      exp_t e;
      if (push) begin
         e.data = ed; e.err = ee; e.lat = el;
         sbQ.push_back(e);
      end
      @(negedge iClock);
      reqWen = w; reqF3 = f3; reqAddr = a; reqData = d; reqValid = 1'b1;
      @(posedge iClock);
      #1 reqValid = 1'b0;
   endtask

   task automatic waitRsp(output int lat, output bit timedOut);
      lat = 0;
      timedOut = 1'b1;
      repeat (10) begin
         @(negedge iClock);
         lat++;
         if (rspValid) begin timedOut = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      iReset = 1'b0;
      repeat (2) @(negedge iClock);
      checks++;
      if ({reqReady, rspValid, rspErr, rdEn, wrEn} !== 5'b10000 || rspData !== 0 ||
          rdAddr !== 0 || wrAddr !== 0 || wrData !== 0 || {m0,m1,m2,m3} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_state: got ready=%b valid=%b err=%b rd=%b wr=%b, need ready=1 others 0",
                  reqReady, rspValid, rspErr, rdEn, wrEn);
      end
      iReset = 1'b1;
      @(negedge iClock);
      checks++;
      if (reqReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready_after_reset: got %b need 1", reqReady);
      end
   endtask

   task automatic test_load();
      logic [2:0]  f3s [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] adrs[5] = '{32'h80000010, 32'h80000003, 32'h80000003, 32'h80000004, 32'h80000006};
      logic [31:0] mems[5] = '{32'h8899AABB, 32'h000000F0, 32'h000000F0, 32'h00008001, 32'h00008001};
      logic [31:0] exps[5] = '{32'h8899AABB, 32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h00008001};
      int lat; bit to; exp_t e; int rd0;
      rspReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         memRet = mems[i];
         rd0 = rdPulses;
         sendReq(1'b0, f3s[i], adrs[i], 32'h0, 1'b1, exps[i], 1'b0, 3);
         checks++;
         if (rdEn !== 1'b1 || rdAddr !== adrs[i]) begin
            errors++;
            $display("[TB] FAIL load_rd_strobe[%0d]: got en=%b addr=%h need en=1 addr=%h", i, rdEn, rdAddr, adrs[i]);
         end
         waitRsp(lat, to);
         e = sbQ.pop_front();
         checks++;
         if (to || lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL load_latency[%0d]: got %0d need %0d", i, lat, e.lat);
         end
         checks++;
         if (rspData !== e.data || rspErr !== e.err) begin
            errors++;
            $display("[TB] FAIL load_data[%0d]: got %h/%b need %h/%b", i, rspData, rspErr, e.data, e.err);
         end
         checks++;
         if (rdPulses - rd0 !== 1 || lastRdAddr !== adrs[i]) begin
            errors++;
            $display("[TB] FAIL load_pulse[%0d]: got %0d pulses addr %h need 1 at %h", i, rdPulses - rd0, lastRdAddr, adrs[i]);
         end
         @(posedge iClock); #1;
      end
   endtask

   task automatic test_store();
      logic [2:0] f3s [3] = '{3'b000, 3'b001, 3'b010};
      logic [3:0] mask[3] = '{4'b0001, 4'b0011, 4'b1111};
      int lat; bit to; exp_t e; int wr0, rd0;
      rspReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr0 = wrPulses; rd0 = rdPulses;
         sendReq(1'b1, f3s[i], 32'h80000020, 32'h12345678, 1'b1, 32'h0, 1'b0, 2);
         waitRsp(lat, to);
         e = sbQ.pop_front();
         checks++;
         if (to || lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL store_latency[%0d]: got %0d need %0d", i, lat, e.lat);
         end
         checks++;
         if (rspData !== e.data || rspErr !== e.err) begin
            errors++;
            $display("[TB] FAIL store_rsp[%0d]: got %h/%b need %h/%b", i, rspData, rspErr, e.data, e.err);
         end
         checks++;
         if (wrPulses - wr0 !== 1 || rdPulses != rd0 || lastWrAddr !== 32'h80000020 ||
             lastWrData !== 32'h12345678 || lastWrMask !== mask[i]) begin
            errors++;
            $display("[TB] FAIL store_bus[%0d]: got pulses=%0d addr=%h data=%h mask=%b need 1 80000020 12345678 %b",
                     i, wrPulses - wr0, lastWrAddr, lastWrData, lastWrMask, mask[i]);
         end
         @(posedge iClock); #1;
      end
   endtask

   task automatic test_error();
      logic        wens[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
      logic [31:0] adrs[4] = '{32'h80000002, 32'h80000001, 32'h80000000, 32'h80000000};
      int lat; bit to; exp_t e; int wr0, rd0;
      rspReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr0 = wrPulses; rd0 = rdPulses;
         sendReq(wens[i], f3s[i], adrs[i], 32'hDEADBEEF, 1'b1, 32'h0, 1'b1, 1);
         waitRsp(lat, to);
         e = sbQ.pop_front();
         checks++;
         if (to || lat !== e.lat) begin
            errors++;
            $display("[TB] FAIL err_latency[%0d]: got %0d need %0d", i, lat, e.lat);
         end
         checks++;
         if (rspData !== e.data || rspErr !== e.err) begin
            errors++;
            $display("[TB] FAIL err_rsp[%0d]: got %h/%b need %h/%b", i, rspData, rspErr, e.data, e.err);
         end
         checks++;
         if (wrPulses != wr0 || rdPulses != rd0) begin
            errors++;
            $display("[TB] FAIL err_no_mem[%0d]: got rd=%0d wr=%0d pulses need 0", i, rdPulses - rd0, wrPulses - wr0);
         end
         @(posedge iClock); #1;
      end
   endtask

   task automatic test_backpressure();
      int lat; bit to; exp_t e; int wr0; logic [31:0] held;
      rspReady = 1'b0;
      memRet = 32'hCAFEF00D;
      sendReq(1'b0, 3'b010, 32'h80000040, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 3);
      waitRsp(lat, to);
      held = rspData;
      wr0 = wrPulses;
      reqWen = 1'b1; reqF3 = 3'b010; reqAddr = 32'h80000044; reqData = 32'h55; reqValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge iClock);
         checks++;
         if (rspValid !== 1'b1 || rspData !== held || reqReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b need 1 %h 0", i, rspValid, rspData, reqReady, held);
         end
      end
      reqValid = 1'b0;
      e = sbQ.pop_front();
      checks++;
      if (to || rspData !== e.data || rspErr !== e.err) begin
         errors++;
         $display("[TB] FAIL bp_data: got %h/%b need %h/%b", rspData, rspErr, e.data, e.err);
      end
      rspReady = 1'b1;
      @(posedge iClock); #1;
      checks++;
      if (rspValid !== 1'b0 || reqReady !== 1'b1 || wrPulses != wr0) begin
         errors++;
         $display("[TB] FAIL bp_retire: got valid=%b ready=%b extra_wr=%0d need 0 1 0", rspValid, reqReady, wrPulses - wr0);
      end
   endtask

   task automatic test_back_to_back();
      logic        wens[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [2:0]  f3s [6] = '{3'b001, 3'b010, 3'b101, 3'b000, 3'b001, 3'b110};
      int lat; bit to; exp_t e; logic [31:0] a, w, ed; logic ee, ill, mis; int el;
      rspReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a = $urandom; w = $urandom;
         memRet = w;
         ill = wens[i] ? (f3s[i] > 3'd2) : (f3s[i] == 3'd3 || f3s[i] > 3'd5);
         mis = (f3s[i][1:0] == 2'b01 && a[0]) || (f3s[i][1:0] == 2'b10 && a[1:0] != 0);
         ee = ill || mis;
         ed = (ee || wens[i]) ? 32'h0 : loadModel(f3s[i], w);
         el = ee ? 1 : (wens[i] ? 2 : 3);
         sendReq(wens[i], f3s[i], a, w, 1'b1, ed, ee, el);
         waitRsp(lat, to);
         e = sbQ.pop_front();
         checks++;
         if (to || lat !== e.lat || rspData !== e.data || rspErr !== e.err) begin
            errors++;
            $display("[TB] FAIL b2b[%0d]: got lat=%0d %h/%b need lat=%0d %h/%b", i, lat, rspData, rspErr, e.lat, e.data, e.err);
         end
         @(posedge iClock); #1;
      end
   endtask

   task automatic test_reset_mid();
      int lat; bit to;
      for (int i = 0; i < 2; i++) begin
         rspReady = 1'b1;
         sendReq(i[0], 3'b010, 32'h80000080, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 0);
         checks++;
         if ((i == 0 ? rdEn : wrEn) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_en_before[%0d]: got %b need 1", i, i == 0 ? rdEn : wrEn);
         end
         #2 iReset = 1'b0;
         #1;
         checks++;
         if ({reqReady, rspValid, rdEn, wrEn} !== 4'b1000 || rdAddr !== 0 || wrAddr !== 0 ||
             wrData !== 0 || {m0,m1,m2,m3} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs[%0d]: got ready=%b valid=%b rd=%b wr=%b need 1 0 0 0",
                     i, reqReady, rspValid, rdEn, wrEn);
         end
         @(negedge iClock);
         iReset = 1'b1;
         waitRsp(lat, to);
         checks++;
         if (!to || reqReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_rsp[%0d]: got rsp=%b ready=%b need rsp=0 ready=1", i, !to, reqReady);
         end
      end
   endtask

   task automatic test_bus_rules();
      checks++;
      if (bothHigh !== 0) begin
         errors++;
         $display("[TB] FAIL rd_wr_overlap: got %0d need 0", bothHigh);
      end
      checks++;
      if (idleLeak !== 0) begin
         errors++;
         $display("[TB] FAIL idle_bus_nonzero: got %0d need 0", idleLeak);
      end
      checks++;
      if (sbQ.size() !== 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_leftover: got %0d need 0", sbQ.size());
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_error();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_bus_rules();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
